// File: rtl/mvb_tx_pkg.sv
// Shared types and constants for the MVB transmit scheduler.
package mvb_tx_pkg;

  // Scheduler sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_GAP       = 3'd3,
    ST_REJECT    = 3'd4
  } tx_state_e;

  // Frame-type encodings driven as {master_frame, slave_frame}.
  localparam logic [1:0] FT_MASTER = 2'b10;
  localparam logic [1:0] FT_SLAVE  = 2'b01;

  // Default timing, in 24 MHz clock cycles.
  localparam int PULSE_CYCLES_DEF   = 8;
  localparam int GAP_CYCLES_DEF     = 48;
  localparam int TIMEOUT_CYCLES_DEF = 40000;

  // The timer reaches zero on the last cycle of a phase, so a phase of
  // N cycles is loaded with N-1.
  function automatic logic [15:0] phase_load(input int cycles);
    return 16'(cycles - 1);
  endfunction

endpackage

// File: rtl/mvb_tx_timer.sv
// 16-bit loadable down-counter shared by the timed scheduler phases.
module mvb_tx_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic        zero
);

  logic [15:0] count_r;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= 16'd0;
    end else if (load) begin
      count_r <= value;
    end else if (count_r != 16'd0) begin
      count_r <= count_r - 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 16'd0);

endmodule

// File: rtl/mvb_tx_scheduler.sv
// Arbitrates the MVB frame encoder between the master poller and the slave
// reply source and sequences strobe, completion wait and inter-frame gap.
module mvb_tx_scheduler
  import mvb_tx_pkg::*;
#(
  parameter int PULSE_CYCLES   = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m_req,
  input  logic [6:0] m_len,
  output logic       m_gnt,
  output logic       m_done,
  input  logic       s_req,
  input  logic [6:0] s_len,
  output logic       s_gnt,
  output logic       s_done,
  output logic       send_frame,
  output logic [6:0] data_length,
  output logic       master_frame,
  output logic       slave_frame,
  input  logic       frame_over,
  output logic       busy,
  output logic       len_err,
  output logic       timeout_err
);

  localparam logic [15:0] LOAD_PULSE   = phase_load(PULSE_CYCLES);
  localparam logic [15:0] LOAD_GAP     = phase_load(GAP_CYCLES);
  localparam logic [15:0] LOAD_TIMEOUT = phase_load(TIMEOUT_CYCLES);

  tx_state_e   state_r;
  logic        owner_slave_r;
  logic        wait_first_r;
  logic        frame_over_r;
  logic        frame_over_rr;
  logic        req_any_s;
  logic        win_slave_s;
  logic [6:0]  win_len_s;
  logic        fo_edge_s;
  logic        timer_load_s;
  logic [15:0] timer_value_s;
  logic        timer_zero_s;

  // Registered copies of frame_over for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_over_r  <= 1'b0;
      frame_over_rr <= 1'b0;
    end else begin
      frame_over_r  <= frame_over;
      frame_over_rr <= frame_over_r;
    end
  end

  // Arbitration, edge qualification and timer reload on each phase entry.
  always_comb begin
    req_any_s     = s_req | m_req;
    win_slave_s   = s_req;
    win_len_s     = s_req ? s_len : m_len;
    // An edge registered in the first WAIT_DONE cycle happened during START.
    fo_edge_s     = frame_over_r & ~frame_over_rr & ~wait_first_r;
    timer_load_s  = 1'b0;
    timer_value_s = 16'd0;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s && (win_len_s != 7'd0)) begin
          timer_load_s  = 1'b1;
          timer_value_s = LOAD_PULSE;
        end else begin
          timer_load_s  = 1'b0;
          timer_value_s = 16'd0;
        end
      end
      ST_START: begin
        if (timer_zero_s) begin
          timer_load_s  = 1'b1;
          timer_value_s = LOAD_TIMEOUT;
        end else begin
          timer_load_s  = 1'b0;
          timer_value_s = 16'd0;
        end
      end
      ST_WAIT_DONE: begin
        if (fo_edge_s || timer_zero_s) begin
          timer_load_s  = 1'b1;
          timer_value_s = LOAD_GAP;
        end else begin
          timer_load_s  = 1'b0;
          timer_value_s = 16'd0;
        end
      end
      default: begin
        timer_load_s  = 1'b0;
        timer_value_s = 16'd0;
      end
    endcase
  end

  mvb_tx_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load_s),
    .value (timer_value_s),
    .zero  (timer_zero_s)
  );

  // Transmission sequencer with registered encoder and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      owner_slave_r <= 1'b0;
      wait_first_r  <= 1'b0;
      m_gnt         <= 1'b0;
      m_done        <= 1'b0;
      s_gnt         <= 1'b0;
      s_done        <= 1'b0;
      send_frame    <= 1'b0;
      data_length   <= 7'd0;
      master_frame  <= 1'b0;
      slave_frame   <= 1'b0;
      busy          <= 1'b0;
      len_err       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      m_gnt        <= 1'b0;
      m_done       <= 1'b0;
      s_gnt        <= 1'b0;
      s_done       <= 1'b0;
      len_err      <= 1'b0;
      timeout_err  <= 1'b0;
      wait_first_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            s_gnt         <= win_slave_s;
            m_gnt         <= ~win_slave_s;
            owner_slave_r <= win_slave_s;
            busy          <= 1'b1;
            if (win_len_s == 7'd0) begin
              state_r <= ST_REJECT;
              len_err <= 1'b1;
              s_done  <= win_slave_s;
              m_done  <= ~win_slave_s;
            end else begin
              state_r     <= ST_START;
              send_frame  <= 1'b1;
              data_length <= win_len_s;
              {master_frame, slave_frame} <= win_slave_s ? FT_SLAVE : FT_MASTER;
            end
          end
        end
        ST_START: begin
          if (timer_zero_s) begin
            state_r      <= ST_WAIT_DONE;
            send_frame   <= 1'b0;
            wait_first_r <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (fo_edge_s) begin
            state_r <= ST_GAP;
            s_done  <= owner_slave_r;
            m_done  <= ~owner_slave_r;
          end else if (timer_zero_s) begin
            state_r     <= ST_GAP;
            timeout_err <= 1'b1;
            s_done      <= owner_slave_r;
            m_done      <= ~owner_slave_r;
          end
        end
        ST_GAP: begin
          if (timer_zero_s) begin
            state_r      <= ST_IDLE;
            busy         <= 1'b0;
            data_length  <= 7'd0;
            master_frame <= 1'b0;
            slave_frame  <= 1'b0;
          end
        end
        ST_REJECT: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          busy         <= 1'b0;
          send_frame   <= 1'b0;
          data_length  <= 7'd0;
          master_frame <= 1'b0;
          slave_frame  <= 1'b0;
        end
      endcase
    end
  end

endmodule
